// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEPTH_DEF  = 1024;
  localparam int unsigned AFULL_DEF  = DEPTH_DEF - 4;
  localparam int unsigned AEMPTY_DEF = 2;

  // Occupancy needs one more bit than the address so that DEPTH itself is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned depth);
    return (depth != 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: synchronous write, read port registered (FWFT=0) or
// combinational (FWFT=1).
module fifo_mem_dp #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter bit          FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (FWFT) begin : g_async_rd
    logic unused_rd;
    assign unused_rd = rd_en ^ reset;
    assign rd_data   = mem[rd_addr];
  end else begin : g_sync_rd
    // Only the output register is reset; the array itself is not.
    logic [WIDTH-1:0] rd_data_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q <= '0;
      end else if (rd_en) begin
        rd_data_q <= mem[rd_addr];
      end
    end
    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds,
// sticky error flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter bit          FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_wrdata,
  input  logic             i_wren,
  input  logic             i_rden,
  input  logic             i_flush,
  input  logic             i_clr_err,
  input  logic [AW:0]      i_afull_th,
  input  logic [AW:0]      i_aempty_th,
  output logic [WIDTH-1:0] o_rddata,
  output logic             o_rdvalid,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_alm_full,
  output logic             o_alm_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  if (DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
  end
  if (AW != $clog2(DEPTH) || (AW + 1) != cnt_width(DEPTH)) begin : g_bad_aw
    $error("sync_fifo_param: AW is derived from DEPTH and must not be overridden");
  end

  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0]   CntOne = (AW + 1)'(1);
  localparam logic [AW:0]   CntMax = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             rd_acc, wr_acc, mem_wr, mem_rd;
  logic [WIDTH-1:0] mem_rdata;

  assign o_full      = (count_q == CntMax);
  assign o_empty     = (count_q == '0);
  assign o_alm_full  = (count_q >= i_afull_th);
  assign o_alm_empty = (count_q <= i_aempty_th);
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_acc = i_rden & ~o_empty;
  assign wr_acc = i_wren & (~o_full | rd_acc);
  assign mem_wr = wr_acc & ~i_flush;
  assign mem_rd = rd_acc & ~i_flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~i_clr_err;
    underflow_d = underflow_q & ~i_clr_err;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CntOne;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CntOne;
      end
      if (i_wren && !wr_acc) overflow_d = 1'b1;
      if (i_rden && !rd_acc) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .FWFT  (FWFT)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (i_wrdata),
    .rd_en   (mem_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    // Gate stale array contents so an empty FIFO presents zero data.
    assign o_rddata  = o_empty ? '0 : mem_rdata;
    assign o_rdvalid = ~o_empty;
  end else begin : g_std
    logic rdvalid_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdvalid_q <= 1'b0;
      end else begin
        rdvalid_q <= mem_rd;
      end
    end
    assign o_rddata  = mem_rdata;
    assign o_rdvalid = rdvalid_q;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the fixed 4-bit-pointer FIFO.
- Width and depth are generic; the pointer width is derived from depth.
- Adds a true occupancy count and runtime-programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer stages sharing one clock domain.

Parameters:
WIDTH, 128, data word width in bits.
DEPTH, 1024, number of entries; must be a power of two and >= 4.
AW, $clog2(DEPTH), derived address width; must not be overridden.
FWFT, 0: 0 = standard registered read (1-cycle latency); 1 = first-word-fall-through.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
i_wrdata  input  WIDTH  write data.
i_wren  input  1  write request.
i_rden  input  1  read request.
i_flush  input  1  synchronous flush; empties the FIFO.
i_clr_err  input  1  synchronous clear of sticky error flags.
i_afull_th  input  AW+1  almost-full threshold.
i_aempty_th  input  AW+1  almost-empty threshold.
o_rddata  output  WIDTH  read data.
o_rdvalid  output  1  o_rddata valid (standard mode: pulse; FWFT: equals !o_empty).
o_count  output  AW+1  current occupancy, 0..DEPTH.
o_full  output  1  count == DEPTH.
o_empty  output  1  count == 0.
o_alm_full  output  1  count >= i_afull_th.
o_alm_empty  output  1  count <= i_aempty_th.
o_overflow  output  1  sticky: a write was rejected.
o_underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (async, immediate, mid-operation included): wr_ptr, rd_ptr and count go to 0.
  - o_rddata = 0, o_rdvalid = 0, o_overflow = 0, o_underflow = 0.
  - o_empty = 1, o_full = 0; o_alm_* follow their compares against count 0.
  - Storage array is not reset.
- Pointers are AW bits and wrap naturally modulo DEPTH. Count is a separate AW+1-bit register; it never wraps.
- All status outputs are combinational decodes of the registered count and pointers only. No combinational path from i_wren/i_rden to the flags.
- Read accept: rd_acc = i_rden & !o_empty.
- Write accept: wr_acc = i_wren & (!o_full | rd_acc).
  - When full, a simultaneous read and write are both accepted; count is unchanged.
  - When empty, a simultaneous read and write: the write is accepted, the read is rejected.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Write: mem[wr_ptr] <= i_wrdata, then wr_ptr increments.
- Read, standard mode (FWFT=0):
  - On rd_acc, o_rddata <= mem[rd_ptr] and rd_ptr increments.
  - o_rdvalid is high for exactly the cycle after rd_acc.
  - o_rddata holds its value otherwise.
- Read, FWFT mode (FWFT=1):
  - o_rddata = mem[rd_ptr] via asynchronous memory read; o_rdvalid = !o_empty.
  - i_rden acts as an acknowledge: rd_ptr advances and the next word appears the following cycle.
  - A word written into an empty FIFO is visible on o_rddata one cycle after the write.
- Errors:
  - o_overflow sets when i_wren & !wr_acc.
  - o_underflow sets when i_rden & !rd_acc.
  - Both hold until i_clr_err or reset. If set and clear occur in the same cycle, set wins.
- Flush: i_flush zeroes the pointers and count next cycle and overrides any same-cycle read or write.
  - Rejected requests during flush do not set error flags.
  - Error flags are otherwise untouched by flush. o_rdvalid = 0 the cycle after flush.
- Thresholds: compared unsigned at full AW+1 width; may change at any time.
  - i_afull_th = 0 makes o_alm_full constantly 1.
  - i_aempty_th >= DEPTH makes o_alm_empty constantly 1.

Decomposition:
- Package fifo_pkg holds:
  - the default threshold constants (AFULL_DEF = DEPTH-4, AEMPTY_DEF = 2);
  - a parametrised count-width helper function;
  - a localparam check (DEPTH power of two) raised as an elaboration-time error.
- One sub-module, fifo_mem_dp: simple dual-port RAM with synchronous write and a read port that is synchronous when FWFT=0 and asynchronous when FWFT=1.
- Pointer/count/flag control stays in sync_fifo_param.

Test Plan:
1. Bench config WIDTH=8, DEPTH=16, FWFT=0, thresholds afull=12, aempty=2.
   - Reset, then write 0x01..0x10 -> o_full=1 and o_count=16 after the 16th write; o_alm_full rises when count reaches 12.
   - Read all 16 -> data 0x01..0x10 in order, each with o_rdvalid one cycle after i_rden; o_empty=1 at end.
2. Full FIFO, simultaneous i_wren (0xAA) and i_rden -> both accepted, o_count stays 16, o_overflow=0, 0xAA is read last.
3. Full FIFO, write only -> o_overflow=1, count stays 16; i_clr_err -> o_overflow=0. Empty FIFO, read only -> o_underflow=1, o_rdvalid stays 0.
4. FWFT=1: write 0x5A into empty FIFO -> o_rddata=0x5A and o_rdvalid=1 the next cycle with no i_rden; pulse i_rden -> o_empty=1 next cycle.
5. Wrap-around: 40 interleaved write/read cycles at count ~8 -> pointers wrap twice, data order preserved, count never exceeds 16.
6. Flush and reset:
   - Assert i_flush with count=9 and i_wren=1 -> count=0, o_empty=1, no error flag set.
   - Assert reset asynchronously mid-burst (between clock edges) -> all outputs immediately take their reset values.
